// File: rtl/ball_split_ctrl.sv
// ----------------------------------------------------------------------------
// ball_split_ctrl
//
// Splits balls for the bouncing-ball game engine. It receives "ball hit by
// shot" events from the shot/ball collision logic. It keeps the slot-active
// bitmap for a fixed pool of ball slots. It drives load and kill commands to
// the per-slot ball movement blocks.
//
// A hit on a live ball kills that slot one cycle after the hit is accepted.
// A smallest ball (size 0) is simply removed. A larger ball splits:
//   - The controller scans the pool for a free slot, one index per cycle.
//   - It reloads the hit slot with a child one size smaller. That child keeps
//     the X speed and gets an upward Y speed.
//   - It loads the first free slot with a second child that has the mirrored
//     X speed.
//   - If no slot is free, the second child is dropped and split_drop pulses.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   start_level     pulse (honoured only while idle): clear the pool and
//                   spawn the INIT_* ball in slot 0
//   hit_valid/ready hit handshake; hit_ready is high only when idle
//   hit_slot/size/xspeed/yspeed
//                   the hit ball; all fields are captured at acceptance
//   load_valid      one-cycle pulse: load load_slot with the load_* values
//   load_slot/size/xspeed/yspeed
//                   spawn parameters; they hold between loads
//   kill_valid      one-cycle pulse: deactivate kill_slot
//   split_drop      pulse: second child lost because the pool is full
//   active_mask     registered slot-active bitmap
//   level_clear     pulse one cycle after active_mask drops to all-zero
//   score           (only with BALL_SPLIT_SCORE_EN) saturating points
//                   counter; each kill adds 4 - size
//
// Optional feature macro: BALL_SPLIT_SCORE_EN adds the score output.
// ----------------------------------------------------------------------------
module ball_split_ctrl #(
  parameter int                NUM_SLOTS   = 8,
  parameter int                SLOT_W      = 3,
  parameter logic signed [10:0] INIT_XSPEED = 11'sd40,
  parameter logic signed [10:0] INIT_YSPEED = -11'sd60,
  parameter logic        [1:0] INIT_SIZE   = 2'd3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_level,
  input  logic                     hit_valid,
  output logic                     hit_ready,
  input  logic [SLOT_W-1:0]        hit_slot,
  input  logic [1:0]               hit_size,
  input  logic signed [10:0]       hit_xspeed,
  input  logic signed [10:0]       hit_yspeed,
  output logic                     load_valid,
  output logic [SLOT_W-1:0]        load_slot,
  output logic [1:0]               load_size,
  output logic signed [10:0]       load_xspeed,
  output logic signed [10:0]       load_yspeed,
  output logic                     kill_valid,
  output logic [SLOT_W-1:0]        kill_slot,
  output logic                     split_drop,
  output logic [NUM_SLOTS-1:0]     active_mask,
  output logic                     level_clear
`ifdef BALL_SPLIT_SCORE_EN
  ,
  output logic [15:0]              score
`endif
);

  localparam int SPD_W = 11;
  localparam logic signed [SPD_W-1:0] SPD_MIN  = {1'b1, {(SPD_W-1){1'b0}}};
  localparam logic signed [SPD_W-1:0] SPD_MAX  = {1'b0, {(SPD_W-1){1'b1}}};
  localparam logic [SLOT_W-1:0]       LAST_IDX = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    LOAD_A = 2'd2,
    LOAD_B = 2'd3
  } state_t;

  state_t state;

  // Hit fields captured at acceptance. They stay stable for the whole split,
  // whatever the requester does afterwards.
  logic [SLOT_W-1:0]        hit_slot_p1;
  logic [1:0]               hit_size_p1;
  logic signed [SPD_W-1:0]  hit_xspeed_p1;
  logic signed [SPD_W-1:0]  hit_yspeed_p1;

  // Free-slot search state.
  logic [SLOT_W-1:0]        scan_idx;
  logic                     scan_found;
  logic [SLOT_W-1:0]        scan_free;

  // Remembers whether the bitmap was non-empty one cycle earlier. This lets
  // level_clear fire exactly once, on the non-zero -> zero transition.
  logic                     mask_was_nz;

  // Mirror an X speed. -1024 has no positive counterpart in 11 bits, so it
  // saturates to +1023.
  function automatic logic signed [SPD_W-1:0] neg_sat(
    input logic signed [SPD_W-1:0] v
  );
    if (v == SPD_MIN) neg_sat = SPD_MAX;
    else              neg_sat = -v;
  endfunction

  // Force a Y speed upward (negative). Values that are already upward pass
  // through unchanged, so -1024 never needs to be negated.
  function automatic logic signed [SPD_W-1:0] up_speed(
    input logic signed [SPD_W-1:0] v
  );
    if (v[SPD_W-1]) up_speed = v;
    else            up_speed = -v;
  endfunction

  // Slot lookup that tolerates indices at or above NUM_SLOTS, which are
  // possible when NUM_SLOTS is not a power of two. Such indices read as
  // inactive.
  function automatic logic is_active(
    input logic [NUM_SLOTS-1:0] m,
    input logic [SLOT_W-1:0]    idx
  );
    is_active = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == SLOT_W'(i)) is_active = m[i];
    end
  endfunction

  function automatic logic [NUM_SLOTS-1:0] slot_bit(
    input logic [SLOT_W-1:0] idx
  );
    slot_bit = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == SLOT_W'(i)) slot_bit[i] = 1'b1;
    end
  endfunction

`ifdef BALL_SPLIT_SCORE_EN
  // Smaller balls are worth more: 4 - size points, saturating at 16'hFFFF.
  function automatic logic [15:0] score_add(
    input logic [15:0] s,
    input logic [1:0]  sz
  );
    logic [16:0] sum;
    sum = {1'b0, s} + 17'(3'd4 - {1'b0, sz});
    if (sum[16]) score_add = 16'hFFFF;
    else         score_add = sum[15:0];
  endfunction
`endif

  assign hit_ready = (state == IDLE) & ~start_level & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      active_mask <= '0;
      load_valid  <= 1'b0;
      load_slot   <= '0;
      load_size   <= '0;
      load_xspeed <= '0;
      load_yspeed <= '0;
      kill_valid  <= 1'b0;
      kill_slot   <= '0;
      split_drop  <= 1'b0;
      level_clear <= 1'b0;
      mask_was_nz <= 1'b0;
      scan_idx    <= '0;
      scan_found  <= 1'b0;
      scan_free   <= '0;
`ifdef BALL_SPLIT_SCORE_EN
      score       <= '0;
`endif
    end else begin
      load_valid  <= 1'b0;
      kill_valid  <= 1'b0;
      split_drop  <= 1'b0;
      mask_was_nz <= |active_mask;
      level_clear <= mask_was_nz & ~(|active_mask);

      case (state)
        // ---- stage p0 -> p1: accept a hit or a level restart ----
        IDLE: begin
          if (start_level) begin
            active_mask <= NUM_SLOTS'(1);
            load_valid  <= 1'b1;
            load_slot   <= '0;
            load_size   <= INIT_SIZE;
            load_xspeed <= INIT_XSPEED;
            load_yspeed <= INIT_YSPEED;
`ifdef BALL_SPLIT_SCORE_EN
            score       <= '0;
`endif
          end else if (hit_valid) begin
            hit_slot_p1   <= hit_slot;
            hit_size_p1   <= hit_size;
            hit_xspeed_p1 <= hit_xspeed;
            hit_yspeed_p1 <= hit_yspeed;
            // A hit on a dead slot (stale collision) is consumed silently.
            if (is_active(active_mask, hit_slot)) begin
              kill_valid  <= 1'b1;
              kill_slot   <= hit_slot;
              active_mask <= active_mask & ~slot_bit(hit_slot);
`ifdef BALL_SPLIT_SCORE_EN
              score       <= score_add(score, hit_size);
`endif
              if (hit_size != 2'd0) begin
                state      <= SCAN;
                scan_idx   <= '0;
                scan_found <= 1'b0;
              end
            end
          end
        end

        // ---- stage p1: scan one slot per cycle for the second child ----
        SCAN: begin
          // The hit slot is already cleared in the bitmap, but the first
          // child reclaims it, so it must not be chosen here as well.
          if (!scan_found && !is_active(active_mask, scan_idx) &&
              (scan_idx != hit_slot_p1)) begin
            scan_found <= 1'b1;
            scan_free  <= scan_idx;
          end
          if (scan_idx == LAST_IDX) begin
            state       <= LOAD_A;
            load_valid  <= 1'b1;
            load_slot   <= hit_slot_p1;
            load_size   <= hit_size_p1 - 2'd1;
            load_xspeed <= hit_xspeed_p1;
            load_yspeed <= up_speed(hit_yspeed_p1);
            active_mask <= active_mask | slot_bit(hit_slot_p1);
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end

        // ---- stage p2: issue the mirrored child or report the drop ----
        LOAD_A: begin
          state <= LOAD_B;
          if (scan_found) begin
            load_valid  <= 1'b1;
            load_slot   <= scan_free;
            load_size   <= hit_size_p1 - 2'd1;
            load_xspeed <= neg_sat(hit_xspeed_p1);
            load_yspeed <= up_speed(hit_yspeed_p1);
            active_mask <= active_mask | slot_bit(scan_free);
          end else begin
            split_drop <= 1'b1;
          end
        end

        // ---- stage p3: second child visible, back to idle ----
        LOAD_B: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_split_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ball_split_ctrl
//
// Bench for ball_split_ctrl. The reference model works at transaction level.
// When a hit is accepted it works out the whole split from the slot-pool
// rules: which slot is killed and when, which free slot receives the second
// child, and the child speeds. It writes every expected output event into
// per-cycle schedule arrays.
//
// A compare process checks the DUT against that schedule on every cycle.
// Directed scenarios with literal expectations come first. Randomized traffic
// follows.
// ----------------------------------------------------------------------------
module tb_ball_split_ctrl;

  localparam int NS   = 8;
  localparam int MAXC = 8192;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_level;
  logic              hit_valid;
  logic              hit_ready;
  logic [2:0]        hit_slot;
  logic [1:0]        hit_size;
  logic signed [10:0] hit_xspeed;
  logic signed [10:0] hit_yspeed;
  logic              load_valid;
  logic [2:0]        load_slot;
  logic [1:0]        load_size;
  logic signed [10:0] load_xspeed;
  logic signed [10:0] load_yspeed;
  logic              kill_valid;
  logic [2:0]        kill_slot;
  logic              split_drop;
  logic [7:0]        active_mask;
  logic              level_clear;
`ifdef BALL_SPLIT_SCORE_EN
  logic [15:0]       score;
`endif

  always #5 clk = ~clk;

  ball_split_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start_level (start_level),
    .hit_valid   (hit_valid),
    .hit_ready   (hit_ready),
    .hit_slot    (hit_slot),
    .hit_size    (hit_size),
    .hit_xspeed  (hit_xspeed),
    .hit_yspeed  (hit_yspeed),
    .load_valid  (load_valid),
    .load_slot   (load_slot),
    .load_size   (load_size),
    .load_xspeed (load_xspeed),
    .load_yspeed (load_yspeed),
    .kill_valid  (kill_valid),
    .kill_slot   (kill_slot),
    .split_drop  (split_drop),
    .active_mask (active_mask),
    .level_clear (level_clear)
`ifdef BALL_SPLIT_SCORE_EN
    ,
    .score       (score)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model state ----------------
  int      cyc        = 0;   // index of the cycle currently visible
  int      busy_until = -1;  // last cycle the controller is not idle
  bit [7:0] m_cur     = '0;  // expected mask in cycle cyc
  bit      nz_prev    = 1'b0;
  bit      started    = 1'b0;

  bit       e_load  [MAXC];
  int       e_lslot [MAXC];
  int       e_lsize [MAXC];
  int       e_lx    [MAXC];
  int       e_ly    [MAXC];
  bit       e_kill  [MAXC];
  int       e_kslot [MAXC];
  bit       e_drop  [MAXC];
  bit [7:0] e_set   [MAXC];
  bit [7:0] e_clr   [MAXC];
  bit       e_force1[MAXC];
  bit       e_lvl   [MAXC];
  bit [7:0] e_mask  [MAXC];
  bit       e_zero  [MAXC];
`ifdef BALL_SPLIT_SCORE_EN
  int       m_score = 0;
  int       e_score [MAXC];
`endif

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic clr_ev(input int k);
    if (k < MAXC) begin
      e_load[k] = 0; e_kill[k] = 0; e_drop[k] = 0;
      e_set[k] = '0; e_clr[k] = '0; e_force1[k] = 0;
    end
  endtask

  task automatic sched_load(input int k, input int slot, input int size,
                            input int x, input int y);
    if (k < MAXC) begin
      e_load[k] = 1; e_lslot[k] = slot; e_lsize[k] = size;
      e_lx[k] = x; e_ly[k] = y; e_set[k][slot] = 1'b1;
    end
  endtask

  // Advance the model over the clock edge that ends cycle cyc. It uses the
  // inputs that were applied during that cycle.
  task automatic model_edge();
    int c, n, fs, x, y, xn, yu;
    bit idle;
    bit [7:0] after, mn;
    c = cyc;
    n = cyc + 1;
    idle = (c > busy_until);
    if (reset) begin
      for (int k = n; k < n + NS + 4; k++) clr_ev(k);
      busy_until = c;
      e_zero[n] = 1; e_lvl[n] = 0; e_mask[n] = '0;
      nz_prev = 0; m_cur = '0;
`ifdef BALL_SPLIT_SCORE_EN
      m_score = 0; e_score[n] = 0;
`endif
    end else begin
      if (idle && start_level) begin
        sched_load(n, 0, 3, 40, -60);
        e_force1[n] = 1;
`ifdef BALL_SPLIT_SCORE_EN
        m_score = 0;
`endif
      end else if (idle && hit_valid && m_cur[hit_slot]) begin
        e_kill[n] = 1; e_kslot[n] = int'(hit_slot); e_clr[n][hit_slot] = 1'b1;
`ifdef BALL_SPLIT_SCORE_EN
        m_score = m_score + 4 - int'(hit_size);
        if (m_score > 65535) m_score = 65535;
`endif
        if (hit_size != 0) begin
          after = m_cur & ~(8'b1 << hit_slot);
          fs = -1;
          for (int i = 0; i < NS; i++)
            if (fs < 0 && !after[i] && i != int'(hit_slot)) fs = i;
          x  = int'(hit_xspeed);
          y  = int'(hit_yspeed);
          xn = (x == -1024) ? 1023 : -x;
          yu = (y < 0) ? y : -y;
          busy_until = c + NS + 2;
          sched_load(c + NS + 1, int'(hit_slot), int'(hit_size) - 1, x, yu);
          if (fs >= 0) sched_load(c + NS + 2, fs, int'(hit_size) - 1, xn, yu);
          else if (c + NS + 2 < MAXC) e_drop[c + NS + 2] = 1;
        end
      end
      mn = e_force1[n] ? 8'h01 : ((m_cur & ~e_clr[n]) | e_set[n]);
      e_lvl[n] = nz_prev && (m_cur == 0);
      nz_prev = (m_cur != 0);
      m_cur = mn;
      e_mask[n] = mn;
      e_zero[n] = 0;
`ifdef BALL_SPLIT_SCORE_EN
      e_score[n] = m_score;
`endif
    end
    cyc = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (cyc <= busy_until && guard < 40) begin
      tick();
      guard++;
    end
  endtask

  task automatic hit_wait(input int slot, input int size, input int x, input int y);
    hit_valid = 1; hit_slot = 3'(slot); hit_size = 2'(size);
    hit_xspeed = 11'(x); hit_yspeed = 11'(y);
    tick();
    hit_valid = 0;
    wait_idle();
  endtask

  function automatic logic signed [10:0] rspd();
    case ($urandom_range(7))
      0:       rspd = -11'sd1024;
      1:       rspd = 11'sd1023;
      2:       rspd = '0;
      default: rspd = 11'($urandom);
    endcase
  endfunction

  // Per-cycle comparison against the model schedule.
  always @(negedge clk) begin
    if (started && cyc < MAXC) begin
      chk("hit_ready", hit_ready, ((cyc > busy_until) && !start_level && !reset) ? 1 : 0);
      chk("load_valid", load_valid, e_load[cyc]);
      if (e_load[cyc]) begin
        chk("load_slot", load_slot, e_lslot[cyc]);
        chk("load_size", load_size, e_lsize[cyc]);
        chk("load_xspeed", load_xspeed, e_lx[cyc]);
        chk("load_yspeed", load_yspeed, e_ly[cyc]);
      end
      chk("kill_valid", kill_valid, e_kill[cyc]);
      if (e_kill[cyc]) chk("kill_slot", kill_slot, e_kslot[cyc]);
      chk("split_drop", split_drop, e_drop[cyc]);
      chk("level_clear", level_clear, e_lvl[cyc]);
      chk("active_mask", active_mask, e_mask[cyc]);
      if (e_zero[cyc]) begin
        chk("rst_load_slot", load_slot, 0);
        chk("rst_load_size", load_size, 0);
        chk("rst_load_x", load_xspeed, 0);
        chk("rst_load_y", load_yspeed, 0);
        chk("rst_kill_slot", kill_slot, 0);
      end
`ifdef BALL_SPLIT_SCORE_EN
      chk("score", score, e_score[cyc]);
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; start_level = 0; hit_valid = 0;
    hit_slot = 0; hit_size = 0; hit_xspeed = 0; hit_yspeed = 0;
    tick();
    started = 1;
    tick();
    chk("lit_rst_mask", active_mask, 0);
    chk("lit_rst_load_valid", load_valid, 0);
    #1 chk("lit_rst_ready", hit_ready, 0);
    reset = 0;
    #1 chk("lit_ready_after_rst", hit_ready, 1);

    // Level start spawns the initial ball in slot 0.
    start_level = 1;
    tick();
    start_level = 0;
    chk("lit_start_load", load_valid, 1);
    chk("lit_start_slot", load_slot, 0);
    chk("lit_start_size", load_size, 3);
    chk("lit_start_x", load_xspeed, 40);
    chk("lit_start_y", load_yspeed, -60);
    chk("lit_start_mask", active_mask, 8'h01);

    // Split slot 0 (size 3). The inputs change right after acceptance.
    hit_valid = 1; hit_slot = 0; hit_size = 3; hit_xspeed = 40; hit_yspeed = 25;
    tick();
    hit_valid = 0; hit_slot = 6; hit_size = 1; hit_xspeed = -7; hit_yspeed = 300;
    chk("lit_split_kill", kill_valid, 1);
    chk("lit_split_kslot", kill_slot, 0);
    chk("lit_split_mask_t1", active_mask, 8'h00);
    tick();
    chk("lit_split_lvl_t2", level_clear, 1);
    repeat (7) tick();
    chk("lit_loadA_valid", load_valid, 1);
    chk("lit_loadA_slot", load_slot, 0);
    chk("lit_loadA_size", load_size, 2);
    chk("lit_loadA_x", load_xspeed, 40);
    chk("lit_loadA_y", load_yspeed, -25);
    chk("lit_loadA_mask", active_mask, 8'h01);
    tick();
    chk("lit_loadB_valid", load_valid, 1);
    chk("lit_loadB_slot", load_slot, 1);
    chk("lit_loadB_x", load_xspeed, -40);
    chk("lit_loadB_y", load_yspeed, -25);
    chk("lit_loadB_mask", active_mask, 8'h03);
    tick();

    // Fill the pool.
    hit_wait(0, 2, 3, 3);
    hit_wait(1, 2, 3, 3);
    hit_wait(0, 1, 3, 3);
    hit_wait(1, 1, 3, 3);
    hit_wait(2, 1, 3, 3);
    hit_wait(3, 1, 3, 3);
    chk("lit_full_mask", active_mask, 8'hFF);

    // Full pool: the second child is dropped; X speed -1024 is kept.
    hit_valid = 1; hit_slot = 5; hit_size = 1; hit_xspeed = -1024; hit_yspeed = -7;
    tick();
    hit_valid = 0;
    repeat (8) tick();
    chk("lit_full_load_slot", load_slot, 5);
    chk("lit_full_load_size", load_size, 0);
    chk("lit_full_load_x", load_xspeed, -1024);
    chk("lit_full_load_y", load_yspeed, -7);
    tick();
    chk("lit_full_drop", split_drop, 1);
    chk("lit_full_noload", load_valid, 0);
    chk("lit_full_mask2", active_mask, 8'hFF);
    tick();

    // Leave only slot 3, then kill it.
    foreach (e_zero[k]) if (k < 8 && k != 3) hit_wait(k, 0, 1, 1);
    chk("lit_single_mask", active_mask, 8'h08);
    hit_valid = 1; hit_slot = 3; hit_size = 0;
    tick();
    hit_valid = 0;
    chk("lit_last_kill_slot", kill_slot, 3);
    chk("lit_last_mask", active_mask, 8'h00);
    tick();
    chk("lit_last_lvl", level_clear, 1);
    #1 chk("lit_last_ready", hit_ready, 1);

    // A hit held during a split is accepted on the first idle cycle.
    start_level = 1;
    tick();
    start_level = 0;
    hit_valid = 1; hit_slot = 0; hit_size = 1; hit_xspeed = 5; hit_yspeed = 5;
    tick();
    repeat (4) tick();
    #1 chk("lit_held_ready_scan", hit_ready, 0);
    repeat (6) tick();
    #1 chk("lit_held_ready_idle", hit_ready, 1);
    tick();
    hit_valid = 0;
    chk("lit_held_kill", kill_valid, 1);
    chk("lit_held_kslot", kill_slot, 0);
    wait_idle();

    // start_level beats a coincident hit.
    start_level = 1; hit_valid = 1; hit_slot = 2; hit_size = 2;
    #1 chk("lit_start_hit_ready", hit_ready, 0);
    tick();
    start_level = 0; hit_valid = 0;
    chk("lit_start_hit_load", load_slot, 0);
    chk("lit_start_hit_kill", kill_valid, 0);
    chk("lit_start_hit_mask", active_mask, 8'h01);

    // Reset in the middle of a scan aborts the split.
    hit_valid = 1; hit_slot = 0; hit_size = 2;
    tick();
    hit_valid = 0;
    repeat (3) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("lit_abort_load", load_valid, 0);
    chk("lit_abort_mask", active_mask, 0);
    chk("lit_abort_lslot", load_slot, 0);
    repeat (NS + 4) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(399) == 0);
      start_level = ($urandom_range(49) == 0);
      hit_valid   = $urandom_range(1) == 1;
      if ($urandom_range(3) != 0 && m_cur != 0) begin
        int s;
        s = $urandom_range(7);
        repeat (8) if (!m_cur[s]) s = (s + 1) % 8;
        hit_slot = 3'(s);
      end else begin
        hit_slot = 3'($urandom_range(7));
      end
      hit_size   = 2'($urandom_range(3));
      hit_xspeed = rspd();
      hit_yspeed = rspd();
      tick();
    end
    reset = 0; start_level = 0; hit_valid = 0;
    repeat (NS + 4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
